keypad_scanner: RTL and testbench

Drives the row lines of the 4x4 synth keypad one at a time, samples the column lines, debounces the result, and presents a stable one-row/one-column pin pattern on its outputs. It is the driving end of the keypad pin interface. Its 8-bit `code` output feeds the keypad encoder's pin1..pin8 inputs directly, with `code[7]` on pin1 and `code[0]` on pin8. A one-cycle `key_valid` pulse marks each new debounced press.

---
 rtl/keypad_scanner.sv | 146 ++++++++++++++
 tb/tb_keypad_scanner.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner: drives the 4x4 keypad rows one at a time, samples the columns through a
// 2-flop synchronizer, debounces press and release, and reports a stable {row,col} code.
module keypad_scanner #(
   parameter int unsigned SCAN_DIV = 4,  // cycles each row is driven, >= 4
   parameter int unsigned DEBOUNCE = 3   // identical samples to accept press/release, >= 1
) (
   input  logic       clk,
   input  logic       nrst,
   input  logic [3:0] col,
   output logic [3:0] row,
   output logic [7:0] code,
   output logic       key_valid,
   output logic       key_held
);

   localparam int unsigned DW = $clog2(SCAN_DIV);
   localparam int unsigned CW = $clog2(DEBOUNCE + 1);
   localparam logic [DW-1:0] DivLast = DW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] CntDone = CW'(DEBOUNCE);
   localparam logic [CW-1:0] CntOne  = CW'(1);

   typedef enum logic [1:0] {StScan, StDebounce, StHeld} state_e;

   state_e          state_q, state_d;
   logic [3:0]      col_m_q, col_s_q;
   logic [DW-1:0]   div_q, div_d;
   logic [1:0]      rsel_q, rsel_d;
   logic [7:0]      cand_q, cand_d;
   logic [CW-1:0]   match_q, match_d;
   logic [CW-1:0]   rel_q, rel_d;
   logic [7:0]      code_q, code_d;
   logic            valid_q, valid_d;
   logic            held_q, held_d;

   logic            tick;
   logic            col_onehot;
   logic [7:0]      sample;
   logic [CW-1:0]   match_inc;
   logic [CW-1:0]   rel_inc;

   assign row        = 4'b1000 >> rsel_q;
   assign tick       = (div_q == DivLast);
   assign sample     = {row, col_s_q};
   assign col_onehot = (col_s_q != 4'd0) && ((col_s_q & (col_s_q - 4'd1)) == 4'd0);
   assign match_inc  = match_q + 1'b1;
   assign rel_inc    = rel_q + 1'b1;

   assign code      = code_q;
   assign key_valid = valid_q;
   assign key_held  = held_q;

   // State register with synchronous active-low reset; also the column synchronizer.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         state_q <= StScan;
         col_m_q <= 4'd0;
         col_s_q <= 4'd0;
         div_q   <= '0;
         rsel_q  <= 2'd0;
         cand_q  <= 8'd0;
         match_q <= '0;
         rel_q   <= '0;
         code_q  <= 8'd0;
         valid_q <= 1'b0;
         held_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         col_m_q <= col;
         col_s_q <= col_m_q;
         div_q   <= div_d;
         rsel_q  <= rsel_d;
         cand_q  <= cand_d;
         match_q <= match_d;
         rel_q   <= rel_d;
         code_q  <= code_d;
         valid_q <= valid_d;
         held_q  <= held_d;
      end
   end

   // Next-state logic: the columns are only examined on the dwell tick.
   always_comb begin
      state_d = state_q;
      div_d   = tick ? '0 : div_q + 1'b1;
      rsel_d  = rsel_q;
      cand_d  = cand_q;
      match_d = match_q;
      rel_d   = rel_q;
      code_d  = code_q;
      valid_d = 1'b0;
      held_d  = held_q;
      if (tick) begin
         case (state_q)
            StScan: begin
               if (col_onehot) begin
                  cand_d  = sample;
                  match_d = CntOne;
                  if (DEBOUNCE == 1) begin
                     code_d  = sample;
                     valid_d = 1'b1;
                     held_d  = 1'b1;
                     state_d = StHeld;
                  end else begin
                     state_d = StDebounce;
                  end
               end else begin
                  // No key, or two keys in this row: keep sweeping.
                  rsel_d = rsel_q + 2'd1;
               end
            end
            StDebounce: begin
               if (sample == cand_q) begin
                  match_d = match_inc;
                  if (match_inc == CntDone) begin
                     code_d  = cand_q;
                     valid_d = 1'b1;
                     held_d  = 1'b1;
                     state_d = StHeld;
                  end
               end else begin
                  state_d = StScan;
                  rsel_d  = rsel_q + 2'd1;
               end
            end
            StHeld: begin
               if (col_s_q == 4'd0) begin
                  if (rel_inc == CntDone) begin
                     code_d  = 8'd0;
                     held_d  = 1'b0;
                     rel_d   = '0;
                     rsel_d  = rsel_q + 2'd1;
                     state_d = StScan;
                  end else begin
                     rel_d = rel_inc;
                  end
               end else begin
                  // Any column activity (even another key in this row) restarts release.
                  rel_d = '0;
               end
            end
            default: state_d = StScan;
         endcase
      end
   end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: keypad model on the row/col lines, a tick-level reference model
// compared every cycle, directed scenarios with literal expectations, then random presses.
module tb_keypad_scanner;

   localparam int unsigned SCAN_DIV = 4;
   localparam int unsigned DEBOUNCE = 3;

   logic       clk = 1'b0;
   logic       nrst = 1'b0;
   logic [3:0] col;
   logic [3:0] row;
   logic [7:0] code;
   logic       key_valid;
   logic       key_held;

   logic [3:0] kp_col [4];  // pressed columns per row line (index = row bit)

   int checks = 0;
   int fails  = 0;
   int vcount = 0;

   keypad_scanner #(
      .SCAN_DIV (SCAN_DIV),
      .DEBOUNCE (DEBOUNCE)
   ) dut (
      .clk       (clk),
      .nrst      (nrst),
      .col       (col),
      .row       (row),
      .code      (code),
      .key_valid (key_valid),
      .key_held  (key_held)
   );

   always #5 clk = ~clk;

   // Physical keypad: a pressed key connects its row line to its column line.
   always_comb begin
      col = 4'd0;
      for (int r = 0; r < 4; r++) begin
         if (row[r]) col = col | kp_col[r];
      end
   end

   // ---------------- reference model (tick-level rules) ----------------
   bit         mvalid = 0;
   int         m_cyc, m_ridx, m_phase, m_streak, m_quiet;  // phase 0 sweep, 1 confirm, 2 held
   logic [7:0] m_cand, m_code;
   logic       m_valid, m_held;
   logic [3:0] m_s1, m_s2;

   function automatic logic [3:0] idx_row(input int i);
      return 4'(1 << (3 - i));
   endfunction

   task automatic m_accept();
      m_code  = m_cand;
      m_valid = 1'b1;
      m_held  = 1'b1;
      m_phase = 2;
      m_quiet = 0;
   endtask

   task automatic m_edge(input logic [3:0] c, input logic n);
      logic [3:0] cs;
      logic [3:0] rv;
      if (!n) begin
         mvalid = 1;
         m_cyc = 0; m_ridx = 0; m_phase = 0; m_streak = 0; m_quiet = 0;
         m_cand = 8'd0; m_code = 8'd0; m_valid = 1'b0; m_held = 1'b0;
         m_s1 = 4'd0; m_s2 = 4'd0;
      end else begin
         cs = m_s2;
         rv = idx_row(m_ridx);
         m_valid = 1'b0;
         if ((m_cyc % SCAN_DIV) == SCAN_DIV - 1) begin
            if (m_phase == 0) begin
               if ($countones(cs) == 1) begin
                  m_cand   = {rv, cs};
                  m_streak = 1;
                  if (m_streak >= DEBOUNCE) m_accept();
                  else m_phase = 1;
               end else begin
                  m_ridx = (m_ridx + 1) % 4;
               end
            end else if (m_phase == 1) begin
               if ({rv, cs} == m_cand) begin
                  m_streak++;
                  if (m_streak >= DEBOUNCE) m_accept();
               end else begin
                  m_phase = 0;
                  m_ridx  = (m_ridx + 1) % 4;
               end
            end else begin
               if (cs == 4'd0) m_quiet++;
               else m_quiet = 0;
               if (m_quiet >= DEBOUNCE) begin
                  m_code  = 8'd0;
                  m_held  = 1'b0;
                  m_quiet = 0;
                  m_phase = 0;
                  m_ridx  = (m_ridx + 1) % 4;
               end
            end
         end
         m_cyc++;
         m_s2 = m_s1;
         m_s1 = c;
      end
   endtask

   // Compare on the falling edge, then advance the model through the coming rising edge.
   always @(negedge clk) begin
      if (mvalid) begin
         checks++;
         if ({row, code, key_valid, key_held} !== {idx_row(m_ridx), m_code, m_valid, m_held}) begin
            fails++;
            $display("FAIL model_cmp t=%0t got row=%b code=%b valid=%b held=%b want row=%b code=%b valid=%b held=%b",
                     $time, row, code, key_valid, key_held, idx_row(m_ridx), m_code, m_valid,
                     m_held);
         end
      end
      if (key_valid === 1'b1) vcount++;
      m_edge(col, nrst);
   end

   // ---------------- directed + random stimulus ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(input string name);
      bit seen = 0;
      for (int i = 0; i < 200 && !seen; i++) begin
         step(1);
         if (key_valid) seen = 1;
      end
      check(name, 32'(seen), 32'd1);
   endtask

   task automatic wait_row(input string name, input logic [3:0] r, input bit eq);
      bit done = 0;
      for (int i = 0; i < 60 && !done; i++) begin
         step(1);
         if ((row == r) == eq) done = 1;
      end
      check(name, 32'(done), 32'd1);
   endtask

   initial begin
      for (int r = 0; r < 4; r++) kp_col[r] = 4'd0;

      // Reset
      nrst = 1'b0;
      step(2);
      check("rst_row", 32'(row), 32'h8);
      check("rst_code", 32'(code), 32'h0);
      check("rst_valid", 32'(key_valid), 32'h0);
      check("rst_held", 32'(key_held), 32'h0);

      // Idle sweep: each row value for SCAN_DIV cycles
      nrst = 1'b1;
      for (int k = 0; k < 20; k++) begin
         check("idle_row", 32'(row), 32'(4'b1000 >> ((k / 4) % 4)));
         step(1);
      end
      check("idle_novalid", 32'(vcount), 32'd0);

      // Press F
      kp_col[2] = 4'b0100;
      wait_valid("pressF_valid");
      check("pressF_code", 32'(code), 32'h44);
      check("pressF_held", 32'(key_held), 32'd1);
      step(1);
      check("pressF_pulse", 32'(key_valid), 32'd0);
      step(20);
      check("pressF_once", 32'(vcount), 32'd1);
      check("pressF_rowfrozen", 32'(row), 32'h4);

      // Short release (2 zero ticks) then key returns
      kp_col[2] = 4'd0;
      step(8);
      kp_col[2] = 4'b0100;
      step(12);
      check("glitch_held", 32'(key_held), 32'd1);
      check("glitch_once", 32'(vcount), 32'd1);

      // Real release
      kp_col[2] = 4'd0;
      begin
         bit rel = 0;
         for (int i = 0; i < 60 && !rel; i++) begin
            step(1);
            if (!key_held) rel = 1;
         end
         check("release_seen", 32'(rel), 32'd1);
      end
      check("release_code", 32'(code), 32'h0);
      check("release_row", 32'(row), 32'h2);

      // Bounce: key seen on the first sample, gone by the second
      wait_row("bounce_reach", 4'b0100, 1);
      kp_col[2] = 4'b0100;
      step(5);
      kp_col[2] = 4'd0;
      wait_row("bounce_leave", 4'b0100, 0);
      check("bounce_row", 32'(row), 32'h2);
      check("bounce_code", 32'(code), 32'h0);
      check("bounce_novalid", 32'(vcount), 32'd1);

      // Multi-hot in one row is ignored
      kp_col[1] = 4'b0110;
      step(48);
      check("multi_novalid", 32'(vcount), 32'd1);
      check("multi_held", 32'(key_held), 32'd0);
      kp_col[1] = 4'd0;

      // Mode key, then reset mid-hold
      kp_col[0] = 4'b0001;
      wait_valid("mode_valid");
      check("mode_code", 32'(code), 32'h11);
      step(5);
      check("mode_count", 32'(vcount), 32'd2);
      nrst = 1'b0;
      step(1);
      check("midrst_row", 32'(row), 32'h8);
      check("midrst_code", 32'(code), 32'h0);
      check("midrst_valid", 32'(key_valid), 32'h0);
      check("midrst_held", 32'(key_held), 32'h0);
      step(1);
      kp_col[0] = 4'd0;
      nrst = 1'b1;
      step(3);

      // Random presses, bounces and occasional resets, checked by the model
      for (int it = 0; it < 80; it++) begin
         int r, dur;
         logic [3:0] c;
         r = $urandom_range(0, 3);
         if ($urandom_range(0, 3) != 0) c = 4'(1 << $urandom_range(0, 3));
         else c = 4'($urandom_range(1, 15));
         dur = $urandom_range(1, 60);
         kp_col[r] = c;
         for (int d = 0; d < dur; d++) begin
            step(1);
            if ($urandom_range(0, 7) == 0) kp_col[r] = (kp_col[r] == 4'd0) ? c : 4'd0;
            if ($urandom_range(0, 299) == 0) nrst = 1'b0;
            else nrst = 1'b1;
         end
         nrst = 1'b1;
         kp_col[r] = 4'd0;
         step($urandom_range(1, 50));
      end

      step(2);
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

endmodule
